// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    ST_RESET = 1'b0,
    ST_RUN   = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetched {pc, instr} entries; flush empties it in one cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned QDEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           flush,
  input  fetch_entry_t                   push_entry,
  output logic [$clog2(QDEPTH+1)-1:0]    count,
  output fetch_entry_t                   head
);

  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);
  localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  fetch_entry_t     r_mem [QDEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: storage is cleared on reset so the head reads as zero until the first push.
      r_mem    <= '{default: '0};
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= push_entry;
        r_wr_ptr        <= next_ptr(r_wr_ptr);
      end
      if (pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      case ({push, pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the fetch PC, issues one-cycle-latency memory reads and
// queues returned words for the core; redirects flush the queue and kill any pending return.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic [31:0]       instr,
  output logic [31:0]       instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       fetch_pc
);

  localparam int unsigned      CNT_W    = $clog2(QDEPTH + 1);
  localparam logic [CNT_W:0]   QDEPTH_C = (CNT_W + 1)'(QDEPTH);

  fetch_state_t     r_state;
  fetch_state_t     w_state_nxt;
  logic [31:0]      r_fetch_pc;
  logic [31:0]      r_issue_pc;
  logic             r_inflight;
  logic             r_kill;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W:0]   w_occupancy;
  logic             w_pop;
  logic             w_push;
  logic             w_flush;
  logic             w_issue;
  logic [31:0]      w_redirect_pc;
  fetch_entry_t     w_head;
  fetch_entry_t     w_push_entry;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_state_nxt   = r_state;
    w_flush       = rst || redirect;
    w_pop         = instr_valid && instr_ready && !redirect;
    w_occupancy   = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight} - {{CNT_W{1'b0}}, w_pop};
    w_issue       = !rst && !redirect && (w_occupancy < QDEPTH_C);
    // A return is dropped if reset or a redirect lands on it, or an older redirect marked it dead.
    w_push        = (r_state == ST_RUN) && r_inflight && !r_kill && !w_flush;
    w_redirect_pc = redirect_pc & ~32'd3;

    if (rst) w_state_nxt = ST_RESET;
    else     w_state_nxt = ST_RUN;
  end

  always_ff @(posedge clk) begin
    r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_issue_pc <= '0;
      r_inflight <= 1'b0;
      r_kill     <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_kill     <= redirect && r_inflight;
      if (w_issue) r_issue_pc <= r_fetch_pc;
      if (redirect)     r_fetch_pc <= w_redirect_pc;
      else if (w_issue) r_fetch_pc <= r_fetch_pc + PC_STEP;
    end
  end

  assign w_push_entry = '{pc: r_issue_pc, instr: mem_rdata};

  fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (w_push),
    .pop        (w_pop),
    .flush      (w_flush),
    .push_entry (w_push_entry),
    .count      (w_count),
    .head       (w_head)
  );

  assign mem_rd_en   = w_issue;
  assign mem_addr    = r_fetch_pc[ADDR_W+1:2];
  assign fetch_pc    = r_fetch_pc;
  assign instr       = w_head.instr;
  assign instr_pc    = w_head.pc;
  assign instr_valid = (w_count != '0);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench: expected accepted entries go into a queue, a monitor pops and compares on each handshake.
module tb_instr_fetch;
  import fetch_pkg::*;

  logic        clk;
  logic        rst;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] fetch_pc;

  int n_checks   = 0;
  int n_errors   = 0;
  int n_accepted = 0;
  fetch_entry_t exp_q[$];

  instr_fetch #(
    .ADDR_W   (8),
    .RESET_PC (32'h0000_0000),
    .QDEPTH   (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .fetch_pc    (fetch_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory word k holds 32'h1000_0000 + k; idle cycles return a poison value.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= 32'h1000_0000 + {24'h0, mem_addr};
    else           mem_rdata <= 32'hDEAD_BEEF;
  end

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return 32'h1000_0000 + {24'h0, pc[9:2]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    exp_q.push_back('{pc: pc, instr: word_at(pc)});
  endtask

  // One cycle: drive inputs just after the rising edge, return at the falling edge for sampling.
  task automatic drive(input logic r, input logic rdy, input logic rd, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    rst         = r;
    instr_ready = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready && !redirect) begin
      fetch_entry_t e;
      n_accepted++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL accept_unexpected: got pc %h instr %h expected none", instr_pc, instr);
      end else begin
        e = exp_q.pop_front();
        check("accept_pc", instr_pc, e.pc);
        check("accept_instr", instr, e.instr);
      end
    end
  end

  initial begin
    rst = 1'b1; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;

    // Reset state
    repeat (3) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      check("rst_fetch_pc", fetch_pc, 32'h0);
      check("rst_rd_en", {31'h0, mem_rd_en}, 32'h0);
      check("rst_valid", {31'h0, instr_valid}, 32'h0);
    end
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);

    // A: first issue right after reset, at RESET_PC
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    check("a0_rd_en", {31'h0, mem_rd_en}, 32'h1);
    check("a0_addr", {24'h0, mem_addr}, 32'h0);
    check("a0_valid", {31'h0, instr_valid}, 32'h0);
    check("a0_instr", instr, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    check("a1_valid", {31'h0, instr_valid}, 32'h0);
    check("a1_fetch_pc", fetch_pc, 32'h4);
    check("a1_rd_en", {31'h0, mem_rd_en}, 32'h1);

    // A+2..A+6: stalled core, queue fills and issue stops, head held
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      check("stall_valid", {31'h0, instr_valid}, 32'h1);
      check("stall_instr", instr, 32'h1000_0000);
      check("stall_pc", instr_pc, 32'h0);
      check("stall_rd_en", {31'h0, mem_rd_en}, 32'h0);
    end

    // A+7..A+12: streaming one per cycle
    for (int k = 0; k < 6; k++) expect_pc(32'(k * 4));
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      check("stream_valid", {31'h0, instr_valid}, 32'h1);
      check("stream_rd_en", {31'h0, mem_rd_en}, 32'h1);
    end

    // A+13: redirect with a read in flight and queue effectively full
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0043);
    check("redir1_rd_en", {31'h0, mem_rd_en}, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    check("redir1_p1_valid", {31'h0, instr_valid}, 32'h0);
    check("redir1_p1_fetch_pc", fetch_pc, 32'h40);
    check("redir1_p1_addr", {24'h0, mem_addr}, 32'h10);
    check("redir1_p1_rd_en", {31'h0, mem_rd_en}, 32'h1);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    check("redir1_p2_valid", {31'h0, instr_valid}, 32'h0);
    expect_pc(32'h40);
    expect_pc(32'h44);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    check("redir1_p3_valid", {31'h0, instr_valid}, 32'h1);
    check("redir1_p3_pc", instr_pc, 32'h40);
    drive(1'b0, 1'b1, 1'b0, 32'h0);

    // A+18: redirect while the head is being accepted; head is discarded
    drive(1'b0, 1'b1, 1'b1, 32'h0000_03FC);
    check("redir2_rd_en", {31'h0, mem_rd_en}, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    check("redir2_p1_valid", {31'h0, instr_valid}, 32'h0);
    check("redir2_p1_addr", {24'h0, mem_addr}, 32'hFF);
    check("redir2_p1_fetch_pc", fetch_pc, 32'h3FC);
    expect_pc(32'h3FC);
    expect_pc(32'h400);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    check("redir2_p2_valid", {31'h0, instr_valid}, 32'h0);
    check("redir2_p2_addr", {24'h0, mem_addr}, 32'h00);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);

    // A+23, A+24: back-to-back redirects, the last wins; PC wraps past 0xFFFF_FFFC
    drive(1'b0, 1'b1, 1'b1, 32'h1234_567B);
    check("b2b_rd_en0", {31'h0, mem_rd_en}, 32'h0);
    drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
    check("b2b_fetch_pc0", fetch_pc, 32'h1234_5678);
    check("b2b_rd_en1", {31'h0, mem_rd_en}, 32'h0);
    check("b2b_valid1", {31'h0, instr_valid}, 32'h0);
    expect_pc(32'hFFFF_FFFC);
    expect_pc(32'h0);
    expect_pc(32'h4);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    check("wrap_fetch_pc0", fetch_pc, 32'hFFFF_FFFC);
    check("wrap_addr0", {24'h0, mem_addr}, 32'hFF);
    check("wrap_valid0", {31'h0, instr_valid}, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    check("wrap_fetch_pc1", fetch_pc, 32'h0);
    check("wrap_addr1", {24'h0, mem_addr}, 32'h00);
    check("wrap_rd_en1", {31'h0, mem_rd_en}, 32'h1);
    check("wrap_valid1", {31'h0, instr_valid}, 32'h0);
    repeat (3) drive(1'b0, 1'b1, 1'b0, 32'h0);

    // A+30: one-cycle reset mid-stream with a read in flight
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    check("mrst_rd_en", {31'h0, mem_rd_en}, 32'h0);
    expect_pc(32'h0);
    expect_pc(32'h4);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    check("mrst_p1_valid", {31'h0, instr_valid}, 32'h0);
    check("mrst_p1_fetch_pc", fetch_pc, 32'h0);
    check("mrst_p1_instr", instr, 32'h0);
    check("mrst_p1_pc", instr_pc, 32'h0);
    check("mrst_p1_rd_en", {31'h0, mem_rd_en}, 32'h1);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    check("mrst_p2_valid", {31'h0, instr_valid}, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    check("mrst_p3_valid", {31'h0, instr_valid}, 32'h1);
    check("mrst_p3_pc", instr_pc, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);

    check("scoreboard_left", 32'(exp_q.size()), 32'h0);
    check("accepted_total", 32'(n_accepted), 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
